// File: rtl/lbp_pkg.sv
// Shared definitions for the local-history branch predictor pattern table:
// default geometry, 2-bit saturating counter encoding and its update rule.
package lbp_pkg;

   localparam int unsigned HIST_BITS_DEF = 10;
   localparam int unsigned QDEPTH_DEF    = 4;

   typedef enum logic [1:0] {
      SN = 2'b00,
      WN = 2'b01,
      WT = 2'b10,
      ST = 2'b11
   } ctr_e;

   localparam ctr_e CTR_RESET = WN;

   // Saturating step: taken moves toward ST, not-taken toward SN, no wrap.
   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      ctr_next = c;
      case (c)
         SN: ctr_next = taken ? WN : SN;
         WN: ctr_next = taken ? WT : SN;
         WT: ctr_next = taken ? ST : WN;
         ST: ctr_next = taken ? ST : WT;
      endcase
   endfunction

endpackage

// File: rtl/lbp_hist_fifo.sv
// In-flight history queue: holds the table index of every accepted lookup
// until its branch resolves. Flush empties the queue and takes priority
// over a push in the same cycle. Full/empty are registered from the
// next-state occupancy so they line up with the count register.
module lbp_hist_fifo
   import lbp_pkg::*;
#(
   parameter int unsigned W     = HIST_BITS_DEF,
   parameter int unsigned DEPTH = QDEPTH_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next pointers and occupancy; flush resets everything to the empty state.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wrap_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_d = wrap_inc(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer, count and status registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CW'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   // Storage write; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/lbp_pht.sv
// Local-history pattern history table: 2^HIST_BITS two-bit saturating
// counters indexed by branch local history. Lookups produce a registered
// prediction and queue their index; resolutions update the counter of the
// oldest queued index.
// Optional build macro LBP_PHT_BYPASS_EN: a lookup that hits the index being
// updated in the same cycle sees the post-update counter instead of the
// pre-update one.
module lbp_pht
   import lbp_pkg::*;
#(
   parameter int unsigned HIST_BITS = HIST_BITS_DEF,
   parameter int unsigned QDEPTH    = QDEPTH_DEF
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 Lookup_Valid,
   input  logic [HIST_BITS-1:0] Lookup_History,
   input  logic                 Resolve_Valid,
   input  logic                 Resolve_Taken,
   input  logic                 Flush,
   output logic                 pred,
   output logic                 pred_valid,
   output logic                 Queue_Full,
   output logic                 Queue_Empty
);

   localparam int unsigned DEPTH = 1 << HIST_BITS;

   ctr_e                 table_q [DEPTH];
   logic [HIST_BITS-1:0] head_hist;
   logic                 fifo_full, fifo_empty;
   logic                 pop, accept;
   ctr_e                 head_ctr, upd_ctr, look_ctr;
   logic                 pred_q, pred_d;
   logic                 pred_valid_q, pred_valid_d;

   // A resolve with nothing in flight is ignored; a pop frees a slot for a
   // same-cycle lookup even when the queue is full.
   assign pop    = Resolve_Valid && !fifo_empty;
   assign accept = Lookup_Valid && !Flush && (!fifo_full || pop);

   lbp_hist_fifo #(
      .W     (HIST_BITS),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (accept),
      .pop_i   (pop),
      .flush_i (Flush),
      .data_i  (Lookup_History),
      .data_o  (head_hist),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Counter update value and lookup result; prediction holds when no lookup is accepted.
   always_comb begin
      head_ctr     = table_q[head_hist];
      upd_ctr      = ctr_next(head_ctr, Resolve_Taken);
      look_ctr     = table_q[Lookup_History];
`ifdef LBP_PHT_BYPASS_EN
      if (pop && (head_hist == Lookup_History)) look_ctr = upd_ctr;
`endif
      pred_d       = pred_q;
      pred_valid_d = accept;
      if (accept) pred_d = look_ctr[1];
   end

   // Counter table: reset to weakly not-taken, one update per pop (also in a flush cycle).
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= CTR_RESET;
      end else if (pop) begin
         table_q[head_hist] <= upd_ctr;
      end
   end

   // Registered prediction outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pred_q       <= 1'b0;
         pred_valid_q <= 1'b0;
      end else begin
         pred_q       <= pred_d;
         pred_valid_q <= pred_valid_d;
      end
   end

   assign pred        = pred_q;
   assign pred_valid  = pred_valid_q;
   assign Queue_Full  = fifo_full;
   assign Queue_Empty = fifo_empty;

endmodule

// File: doc/lbp_pht.md
LBP_PHT -- requirements
Module: lbp_pht

Interface
REQ-001 Parameter HIST_BITS, default 10, width of local history used as table index (table depth 2^HIST_BITS).
REQ-002 Parameter QDEPTH, default 4, number of in-flight predictions awaiting resolution.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 Lookup_Valid  input  1  IF-stage lookup request this cycle.
REQ-006 Lookup_History  input  HIST_BITS  local history of the fetched branch, from the history stage.
REQ-007 Resolve_Valid  input  1  ID stage resolved the oldest in-flight branch this cycle.
REQ-008 Resolve_Taken  input  1  actual direction of the resolved branch.
REQ-009 Flush  input  1  discard all in-flight predictions.
REQ-010 pred  output  1  registered taken/not-taken prediction.
REQ-011 pred_valid  output  1  pred corresponds to an accepted lookup from the previous cycle.
REQ-012 Queue_Full  output  1  QDEPTH entries in flight; Queue_Empty  output  1  zero entries in flight.

Function
REQ-013 Table SHALL hold 2^HIST_BITS 2-bit saturating counters: SN=00, WN=01, WT=10, ST=11.
REQ-014 Lookup accepted when Lookup_Valid=1, Flush=0, and (Queue_Full=0 or a pop occurs the same cycle).
REQ-015 Accepted lookup: next cycle pred = MSB of counter[Lookup_History], pred_valid=1; Lookup_History pushed to queue tail.
REQ-016 Non-accepted cycle: next cycle pred_valid=0, pred holds previous value.
REQ-017 Pop occurs when Resolve_Valid=1 and Queue_Empty=0; the head history indexes the counter to update.
REQ-018 Update: taken increments, not-taken decrements, saturating at ST and SN; no wrap.
REQ-019 Resolve_Valid with queue empty SHALL be ignored (no table or queue change), including when a push occurs that same cycle.
REQ-020 Push and pop in same cycle: count unchanged, both pointers advance modulo QDEPTH.
REQ-021 Flush: queue emptied next cycle; a valid pop in the flush cycle still updates the table; lookup in flush cycle dropped; counters otherwise untouched.
REQ-022 Same-cycle lookup and update to one index: lookup reads the pre-update counter (see REQ-027).
REQ-023 Queue_Full/Queue_Empty SHALL be registered, derived from the occupancy count (0..QDEPTH).

Reset
REQ-024 On RESET=1 at a rising edge: all counters to WN, queue empty, pred=0, pred_valid=0, Queue_Empty=1, Queue_Full=0.
REQ-025 RESET SHALL override Flush, lookup and resolve in the same cycle; in-flight entries discarded, no update applied.

Configuration
REQ-026 Macro LBP_PHT_BYPASS_EN selects same-index forwarding.
REQ-027 Defined: same-cycle lookup hitting the index being updated returns the post-update counter MSB; undefined: pre-update MSB per REQ-022.

Structure
REQ-028 Package lbp_pkg SHALL hold HIST_BITS and QDEPTH defaults, the 2-bit counter state enum, and the WN reset constant.
REQ-029 Queue SHALL be sub-module lbp_hist_fifo (push/pop/flush, count, full/empty); table and counter update stay in lbp_pht.

Verification
REQ-030 Reset, lookup history 0x155 -> next cycle pred=0, pred_valid=1 (WN).
REQ-031 Push 0x155, resolve taken; repeat twice -> lookup 0x155 gives pred=1; third taken leaves counter ST (saturated), two not-taken then give pred=0.
REQ-032 Four lookups with no resolve -> Queue_Full=1; fifth lookup alone -> pred_valid=0; fifth lookup with Resolve_Valid=1 -> accepted, count stays 4.
REQ-033 Three lookups in flight, Flush=1 with Resolve_Valid=1 -> head counter updated once, Queue_Empty=1 next cycle, later resolves ignored.
REQ-034 Counter 0x2A at WT, same-cycle lookup 0x2A and not-taken resolve of 0x2A -> pred=1 without LBP_PHT_BYPASS_EN, pred=0 with it.
REQ-035 Resolve_Valid on empty queue with lookup same cycle -> table unchanged, count becomes 1.
